psr_merge_sched: RTL and testbench

Synchronous scheduler that shares one confluence (merge) buffer among N_REQ pulse sources. Each source's pulses are queued in a per-source pending counter. The block issues them to the merge input one at a time, round-robin. Issued pulses are at least T_SEP cycles apart, so the merge never sees a separation-time violation. It sits directly in front of the confluence buffer and replaces ad-hoc OR-merging of pulse streams.

---
 rtl/psr_merge_sched.sv | 154 +++++++++++++++
 tb/tb_psr_merge_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/psr_merge_sched.sv
// psr_merge_sched: round-robin scheduler sharing one confluence buffer among N_REQ pulse
// sources, spacing issued pulses >= T_SEP cycles. Define PSR_MERGE_SCHED_STATS_EN for drop_cnt.

module psr_pend_cnt #(
   parameter int CNT_W = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic dec_i,
   output logic nz_o,
   output logic lost_o
);
   localparam logic [CNT_W-1:0] MAX = '1;

   logic [CNT_W-1:0] pend_q, pend_d;

   // dec_i is only ever raised for a nonzero counter, so no underflow guard is needed
   always_comb begin
      pend_d = pend_q;
      lost_o = 1'b0;
      if (inc_i && !dec_i) begin
         if (pend_q == MAX) lost_o = 1'b1;
         else               pend_d = pend_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         pend_d = pend_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pend_q <= '0;
      else        pend_q <= pend_d;

   assign nz_o = |pend_q;
endmodule

module psr_merge_sched #(
   parameter int N_REQ = 4,
   parameter int T_SEP = 10,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_pulse,
   input  logic             ovf_clr,
   output logic             out_pulse,
   output logic [N_REQ-1:0] grant,
   output logic [N_REQ-1:0] overflow,
   output logic             busy
`ifdef PSR_MERGE_SCHED_STATS_EN
   ,
   output logic [15:0]      drop_cnt
`endif
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int GW = (T_SEP > 1) ? $clog2(T_SEP) : 1;
   localparam logic [GW-1:0] G_LOAD  = GW'((T_SEP > 1) ? T_SEP - 2 : 0);
   localparam logic [PW-1:0] PTR_RST = PW'(N_REQ - 1);

   typedef enum logic [1:0] {IDLE, FIRE, GUARD} state_e;

   state_e           state_q;
   logic [GW-1:0]    gcnt_q;
   logic [PW-1:0]    ptr_q, win;
   logic [N_REQ-1:0] nz, lost, win_oh, ovf_q, grant_q;
   logic             out_q, any_pend, decide;

   for (genvar i = 0; i < N_REQ; i++) begin : g_src
      psr_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk    (clk),
         .rst_n  (rst_n),
         .inc_i  (req_pulse[i]),
         .dec_i  (win_oh[i]),
         .nz_o   (nz[i]),
         .lost_o (lost[i])
      );
   end

   assign any_pend = |nz;

   // Scan from farthest to nearest so the first nonzero source after ptr is the final pick
   always_comb begin
      logic [PW-1:0] idx;
      win = ptr_q;
      idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = PW'((int'(ptr_q) + k) % N_REQ);
         if (nz[idx]) win = idx;
      end
   end

   assign decide = any_pend && ((state_q == IDLE) ||
                                (state_q == FIRE && T_SEP == 1) ||
                                (state_q == GUARD && gcnt_q == '0));
   assign win_oh = decide ? (N_REQ'(1) << win) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gcnt_q  <= '0;
         ptr_q   <= PTR_RST;
         out_q   <= 1'b0;
         grant_q <= '0;
      end else begin
         out_q   <= decide;
         grant_q <= win_oh;
         if (decide) ptr_q <= win;
         case (state_q)
            IDLE:  if (decide) state_q <= FIRE;
            FIRE: begin
               if (T_SEP == 1) begin
                  state_q <= decide ? FIRE : IDLE;
               end else begin
                  state_q <= GUARD;
                  gcnt_q  <= G_LOAD;
               end
            end
            GUARD: begin
               if (gcnt_q != '0) gcnt_q  <= gcnt_q - 1'b1;
               else              state_q <= decide ? FIRE : IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A set in the same cycle as a clear keeps the flag
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ovf_q <= '0;
      else        ovf_q <= lost | (ovf_q & ~{N_REQ{ovf_clr}});

   assign out_pulse = out_q;
   assign grant     = grant_q;
   assign overflow  = ovf_q;
   assign busy      = (state_q != IDLE) || any_pend;

`ifdef PSR_MERGE_SCHED_STATS_EN
   logic [15:0] drop_q;
   logic [16:0] drop_sum;

   always_comb begin
      drop_sum = ovf_clr ? 17'd0 : {1'b0, drop_q};
      for (int i = 0; i < N_REQ; i++) drop_sum = drop_sum + 17'(lost[i]);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) drop_q <= '0;
      else        drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

   assign drop_cnt = drop_q;
`else
   // Lost pulses are visible only through the sticky overflow flags
`endif
endmodule

// File: tb/tb_psr_merge_sched.sv
// Bench for psr_merge_sched: queue-level reference model checked every cycle, plus directed
// literal expectations (default build and a T_SEP=1 instance).
module tb_psr_merge_sched;
  localparam int N = 4, TS = 10, CW = 3, MAXP = (1 << CW) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, req1 = '0;
  logic clr = 1'b0, clr1 = 1'b0;
  logic out, out1, busy, busy1;
  logic [N-1:0] gnt, ovf, gnt1, ovf1;
`ifdef PSR_MERGE_SCHED_STATS_EN
  logic [15:0] drop, drop1;
`endif
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  psr_merge_sched #(.N_REQ(N), .T_SEP(TS), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_pulse(req), .ovf_clr(clr),
    .out_pulse(out), .grant(gnt), .overflow(ovf), .busy(busy)
`ifdef PSR_MERGE_SCHED_STATS_EN
    , .drop_cnt(drop)
`endif
  );

  psr_merge_sched #(.N_REQ(N), .T_SEP(1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_pulse(req1), .ovf_clr(clr1),
    .out_pulse(out1), .grant(gnt1), .overflow(ovf1), .busy(busy1)
`ifdef PSR_MERGE_SCHED_STATS_EN
    , .drop_cnt(drop1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: queues of pending pulses, plus "a decision may happen once T_SEP-1
  // cycles have elapsed since the last issued pulse".
  int m_pend[N];
  logic [N-1:0] m_ovf, m_grant;
  logic m_out;
  int m_ptr, m_last, m_cyc = 0, m_drop;

  always @(posedge clk or negedge rst_n) begin
    int w, lost, base;
    logic [N-1:0] set_ovf;
    bit any;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_pend[i] <= 0;
      m_ovf <= '0; m_grant <= '0; m_out <= 1'b0;
      m_ptr <= N - 1; m_last <= -1000; m_drop <= 0;
    end else begin
      w = -1; lost = 0; set_ovf = '0; any = 0;
      for (int i = 0; i < N; i++) if (m_pend[i] > 0) any = 1;
      if (any && m_cyc >= m_last + TS - 1)
        for (int k = 1; k <= N; k++)
          if (w < 0 && m_pend[(m_ptr + k) % N] > 0) w = (m_ptr + k) % N;
      for (int i = 0; i < N; i++) begin
        if (req[i] && w != i && m_pend[i] == MAXP) begin
          lost++; set_ovf[i] = 1'b1;
        end else begin
          m_pend[i] <= m_pend[i] + int'(req[i]) - ((w == i) ? 1 : 0);
        end
      end
      m_ovf <= clr ? set_ovf : (m_ovf | set_ovf);
      base = clr ? 0 : m_drop;
      m_drop <= (base + lost > 65535) ? 65535 : base + lost;
      m_out <= (w >= 0);
      m_grant <= (w >= 0) ? (N'(1) << w) : '0;
      if (w >= 0) begin
        m_ptr <= w;
        m_last <= m_cyc + 1;
      end
      m_cyc <= m_cyc + 1;
    end
  end

  int ncyc = 0, last_rise = -1000;
  logic prev_out = 1'b0;

  always @(negedge clk) begin
    bit mb;
    mb = 0;
    for (int i = 0; i < N; i++) if (m_pend[i] > 0) mb = 1;
    check("out_pulse", 32'(out), 32'(m_out));
    check("grant", 32'(gnt), 32'(m_grant));
    check("overflow", 32'(ovf), 32'(m_ovf));
    check("busy", 32'(busy), 32'(mb || (m_cyc < m_last + TS)));
`ifdef PSR_MERGE_SCHED_STATS_EN
    check("drop_cnt", 32'(drop), 32'(m_drop));
`endif
    if (out === 1'b1 && prev_out !== 1'b1) begin
      if (last_rise > -1000) check("sep_at_least_TSEP", 32'(ncyc - last_rise >= TS), 1);
      last_rise <= ncyc;
    end
    prev_out <= out;
    ncyc <= ncyc + 1;
  end

  initial begin
    int cnt;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(out), 0);
    check("rst_grant", 32'(gnt), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_busy1", 32'(busy1), 0);
    rst_n = 1'b1;
    tick(3);

    // Round robin from reset pointer: one pulse on every source
    req = 4'b1111; tick(1); req = '0;
    tick(1);  check("rr_c2", 32'(gnt), 1); check("rr_c2_out", 32'(out), 1);
    tick(10); check("rr_c12", 32'(gnt), 2);
    tick(10); check("rr_c22", 32'(gnt), 4);
    tick(10); check("rr_c32", 32'(gnt), 8);
    tick(10); check("rr_c42_out", 32'(out), 0); check("rr_c42_busy", 32'(busy), 0);

    // Fairness: source 0 every cycle, source 2 once; then load source 1 and reset
    req = 4'b0101;
    for (int t = 1; t <= 37; t++) begin
      tick(1);
      req = (t < 30) ? 4'b0001 : 4'b0000;
      if (t >= 33 && t <= 35) req = 4'b0010;
      if (t == 2)  check("fair_g1", 32'(gnt), 1);
      if (t == 12) check("fair_g2", 32'(gnt), 4);
      if (t == 12) check("fair_ovf0", 32'(ovf[0]), 1);
      if (t == 22) check("fair_g3", 32'(gnt), 1);
      if (t == 32) check("fair_g4", 32'(gnt), 1);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(out), 0);
    check("midrst_grant", 32'(gnt), 0);
    check("midrst_ovf", 32'(ovf), 0);
    check("midrst_busy", 32'(busy), 0);
    tick(2);
    rst_n = 1'b1;
    cnt = 0;
    for (int t = 0; t < 30; t++) begin
      tick(1);
      if (out === 1'b1) cnt++;
    end
    check("post_rst_pulses", 32'(cnt), 0);

    // Single request: out at c+2, idle again at c+12
    req = 4'b0001; tick(1); req = '0;
    check("single_c1_out", 32'(out), 0);
    tick(1); check("single_c2_out", 32'(out), 1); check("single_c2_grant", 32'(gnt), 1);
    tick(1); check("single_c3_out", 32'(out), 0); check("single_c3_grant", 32'(gnt), 0);
    tick(8); check("single_c11_busy", 32'(busy), 1);
    tick(1); check("single_c12_busy", 32'(busy), 0);
    tick(2);

    // Overflow clear racing a saturating increment on source 3
    for (int t = 0; t <= 8; t++) begin
      req = 4'b1000; clr = (t == 8); tick(1);
    end
    req = '0; clr = 1'b1;
    check("race_ovf3_kept", 32'(ovf), 8);
`ifdef PSR_MERGE_SCHED_STATS_EN
    check("race_drop", 32'(drop), 1);
`endif
    tick(1); clr = 1'b0;
    check("clr_ovf", 32'(ovf), 0);
`ifdef PSR_MERGE_SCHED_STATS_EN
    check("clr_drop", 32'(drop), 0);
`endif
    // More drops on two sources, then drain under model checking
    req = 4'b1010; tick(8); req = '0;
    tick(150);

    // T_SEP=1 instance: back-to-back pulses
    req1 = 4'b0011; tick(1);
    req1 = 4'b0011; tick(1);
    req1 = '0;
    check("t1_c2", 32'({out1, gnt1}), 32'h11);
    tick(1); check("t1_c3", 32'({out1, gnt1}), 32'h12);
    tick(1); check("t1_c4", 32'({out1, gnt1}), 32'h11);
    tick(1); check("t1_c5", 32'({out1, gnt1}), 32'h12);
    tick(1); check("t1_c6_out", 32'(out1), 0); check("t1_c6_busy", 32'(busy1), 0);
    check("t1_ovf", 32'(ovf1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
